fp32_mul_result_buf: RTL and testbench

FP32_MUL_RESULT_BUF -- requirements
Module: fp32_mul_result_buf

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp32_mul_result_buf_if.sv | 30 +++
 rtl/fp32_classify.sv | 29 ++
 rtl/fp32_mul_result_buf.sv | 131 +++++++++++++
 tb/tb_fp32_mul_result_buf.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 types for the multiplier result buffer.
// Field widths, class encoding and the stored FIFO entry.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        ZERO   = 2'b01,
        INF    = 2'b10,
        NAN    = 2'b11
    } fp_class_e;

    typedef struct packed {
        logic [31:0] data;
        fp_class_e   cls;
    } fifo_entry_t;

endpackage

// File: rtl/fp32_mul_result_buf_if.sv
// Result-in / buffered-out streams of the FP32 result buffer.
// master = multiplier + consumer side, slave = the buffer.
interface fp32_mul_result_buf_if;

    logic        s_axis_result_tvalid;
    logic [31:0] s_axis_result_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;

    modport master (
        output s_axis_result_tvalid,
        output s_axis_result_tdata,
        output m_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  m_axis_tuser
    );

    modport slave (
        input  s_axis_result_tvalid,
        input  s_axis_result_tdata,
        input  m_axis_tready,
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tuser
    );

endinterface

// File: rtl/fp32_classify.sv
// Combinational IEEE 754 binary32 classifier.
// Zero is reported for either sign; subnormals count as normal.
module fp32_classify
    import fp_pkg::*;
(
    input  logic [31:0] i_word,
    output fp_class_e   o_class
);

    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;
    logic              w_unused_sign;

    assign w_exp         = i_word[MANT_W +: EXP_W];
    assign w_mant        = i_word[MANT_W-1:0];
    assign w_unused_sign = i_word[31];

    // Decode exponent/mantissa pattern into the 2-bit class
    always_comb begin
        o_class = NORMAL;
        unique case (1'b1)
            (&w_exp) && (|w_mant):  o_class = NAN;
            (&w_exp) && !(|w_mant): o_class = INF;
            !(|w_exp) && !(|w_mant): o_class = ZERO;
            default:                o_class = NORMAL;
        endcase
    end

endmodule

// File: rtl/fp32_mul_result_buf.sv
// Credit-managed FIFO buffering FP32 multiplier results with class tags.
// Optional FP_CLASS_STATS_EN adds saturating NaN/Inf push counters.
module fp32_mul_result_buf
    import fp_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       issue_valid,
    output logic                       issue_ok,
    fp32_mul_result_buf_if.slave       bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf_err,
    output logic                       credit_err
`ifdef FP_CLASS_STATS_EN
    ,
    output logic [15:0]                nan_cnt,
    output logic [15:0]                inf_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW:0]   DEPTH_S = (LW+1)'(DEPTH);

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
        MUL_LATENCY < 1) begin : g_bad_cfg
        $error("fp32_mul_result_buf: unsupported DEPTH/MUL_LATENCY");
    end

    fifo_entry_t       r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     r_inflight;
    logic              r_ovf;
    logic              r_cerr;

    fp_class_e         w_cls;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [LW:0]       w_sum;

    fp32_classify u_classify (
        .i_word  (bus.s_axis_result_tdata),
        .o_class (w_cls)
    );

    assign w_full = (r_level == DEPTH_L);
    assign w_pop  = (r_level != '0) && bus.m_axis_tready;
    assign w_push = bus.s_axis_result_tvalid && (!w_full || w_pop);
    assign w_sum  = {1'b0, r_level} + {1'b0, r_inflight};

    assign issue_ok   = (w_sum < DEPTH_S);
    assign level      = r_level;
    assign ovf_err    = r_ovf;
    assign credit_err = r_cerr;

    assign bus.m_axis_tvalid = (r_level != '0);
    assign bus.m_axis_tdata  = r_mem[r_rptr].data;
    assign bus.m_axis_tuser  = r_mem[r_rptr].cls;

    // Storage write; contents are meaningless until level covers them
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{data: bus.s_axis_result_tdata, cls: w_cls};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (w_pop && !w_push) r_level <= r_level - LW'(1);
        end
    end

    // Issued-but-not-returned count, clamped to 0..DEPTH
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_inflight <= '0;
        end else if (issue_valid && !bus.s_axis_result_tvalid) begin
            if (r_inflight != DEPTH_L) r_inflight <= r_inflight + LW'(1);
        end else if (!issue_valid && bus.s_axis_result_tvalid) begin
            if (r_inflight != '0) r_inflight <= r_inflight - LW'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ovf  <= 1'b0;
            r_cerr <= 1'b0;
        end else begin
            if (bus.s_axis_result_tvalid && !w_push) r_ovf <= 1'b1;
            if (issue_valid && !issue_ok)            r_cerr <= 1'b1;
        end
    end

`ifdef FP_CLASS_STATS_EN
    logic [15:0] r_nan_cnt;
    logic [15:0] r_inf_cnt;

    assign nan_cnt = r_nan_cnt;
    assign inf_cnt = r_inf_cnt;

    // Saturating per-class counters of accepted pushes
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_nan_cnt <= '0;
            r_inf_cnt <= '0;
        end else if (w_push) begin
            if (w_cls == NAN && r_nan_cnt != 16'hFFFF)
                r_nan_cnt <= r_nan_cnt + 16'd1;
            if (w_cls == INF && r_inf_cnt != 16'hFFFF)
                r_inf_cnt <= r_inf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_mul_result_buf.sv
// Randomized self-checking bench for fp32_mul_result_buf.
// Queue-based reference model; honours FP_CLASS_STATS_EN.
module tb_fp32_mul_result_buf;

    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic                  issue_valid;
    logic                  issue_ok;
    logic [$clog2(DEPTH):0] level;
    logic                  ovf_err;
    logic                  credit_err;
`ifdef FP_CLASS_STATS_EN
    logic [15:0]           nan_cnt;
    logic [15:0]           inf_cnt;
`endif

    fp32_mul_result_buf_if bus();

    fp32_mul_result_buf #(
        .DEPTH       (DEPTH),
        .MUL_LATENCY (LAT)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .issue_valid (issue_valid),
        .issue_ok    (issue_ok),
        .bus         (bus),
        .level       (level),
        .ovf_err     (ovf_err),
        .credit_err  (credit_err)
`ifdef FP_CLASS_STATS_EN
        ,
        .nan_cnt     (nan_cnt),
        .inf_cnt     (inf_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int   n_chk = 0;
    int   n_err = 0;

    ent_t mq[$];
    int   m_infl;
    bit   m_ovf;
    bit   m_cerr;
    int   m_nan;
    int   m_inf;
    bit   pipe[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_class(input logic [31:0] d);
        int e;
        int m;
        e = int'(d[30:23]);
        m = int'(d[22:0]);
        if (e == 255) return (m != 0) ? 3 : 2;
        if (e == 0 && m == 0) return 1;
        return 0;
    endfunction

    task automatic check_all();
        chk("tvalid", 32'(bus.m_axis_tvalid), 32'(mq.size() != 0));
        chk("level", 32'(level), mq.size());
        chk("issue_ok", 32'(issue_ok), 32'((mq.size() + m_infl) < DEPTH));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("credit_err", 32'(credit_err), 32'(m_cerr));
        if (mq.size() != 0) begin
            chk("tdata", bus.m_axis_tdata, mq[0].d);
            chk("tuser", 32'(bus.m_axis_tuser), mq[0].c);
        end
`ifdef FP_CLASS_STATS_EN
        chk("nan_cnt", 32'(nan_cnt), m_nan);
        chk("inf_cnt", 32'(inf_cnt), m_inf);
`endif
    endtask

    // Called at a falling edge: drive, advance model, clock, check.
    task automatic step(input logic rst, input logic iv, input logic rv,
                        input logic [31:0] rd, input logic rdy);
        areset                   = rst;
        issue_valid              = iv;
        bus.s_axis_result_tvalid = rv;
        bus.s_axis_result_tdata  = rd;
        bus.m_axis_tready        = rdy;
        if (rst) begin
            mq.delete();
            m_infl = 0;
            m_ovf  = 0;
            m_cerr = 0;
            m_nan  = 0;
            m_inf  = 0;
        end else begin
            if (iv && !((mq.size() + m_infl) < DEPTH)) m_cerr = 1;
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (rv) begin
                if (mq.size() < DEPTH) begin
                    ent_t e;
                    e.d = rd;
                    e.c = ref_class(rd);
                    mq.push_back(e);
                    if (e.c == 3 && m_nan < 65535) m_nan++;
                    if (e.c == 2 && m_inf < 65535) m_inf++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (iv && !rv && m_infl < DEPTH) m_infl++;
            else if (rv && !iv && m_infl > 0) m_infl--;
        end
        @(posedge aclk);
        @(negedge aclk);
        check_all();
    endtask

    task automatic pipe_clear();
        pipe.delete();
        for (int i = 0; i < LAT; i++) pipe.push_back(1'b0);
    endtask

    task automatic mul_step(input logic iv, input logic rdy,
                            input logic [31:0] rd);
        logic rv;
        rv = pipe.pop_front();
        pipe.push_back(iv);
        step(1'b0, iv, rv, rd, rdy);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] sp[6];
        sp[0] = 32'h7FC00000;
        sp[1] = 32'h7F800000;
        sp[2] = 32'hFF800000;
        sp[3] = 32'h80000000;
        sp[4] = 32'h00000000;
        sp[5] = 32'hFF812345;
        if ($urandom_range(0, 9) < 3) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        areset                   = 1'b1;
        issue_valid              = 1'b0;
        bus.s_axis_result_tvalid = 1'b0;
        bus.s_axis_result_tdata  = '0;
        bus.m_axis_tready        = 1'b0;
        @(negedge aclk);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // single result with empty FIFO, 1-cycle latency then gone
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h3F800000, 1'b1);
        chk("one_valid", 32'(bus.m_axis_tvalid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("one_gone", 32'(bus.m_axis_tvalid), 32'd0);

        // fill via 8 credited issues with consumer stalled
        pipe_clear();
        for (int i = 0; i < DEPTH; i++)
            mul_step(1'b1, 1'b0, 32'h40000000 + 32'(i));
        chk("credit_out", 32'(issue_ok), 32'd0);
        for (int i = 0; i < LAT; i++)
            mul_step(1'b0, 1'b0, 32'h40000000 + 32'(DEPTH - LAT + i));
        chk("full_level", 32'(level), DEPTH);

        // overflow drop, then push+pop at full
        step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1);
        chk("pushpop_lvl", 32'(level), DEPTH);

        // issue without credit, sticky error
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("cerr_set", 32'(credit_err), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // class tags in order
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h7F800000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h00000001, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // reset mid-operation with level=5, inflight=2
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 32'h3F000000 + 32'(i), 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_ok", 32'(issue_ok), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h3F800000, 1'b0);

        // randomized credited traffic
        pipe_clear();
        for (int i = 0; i < 400; i++) begin
            logic iv;
            iv = ((mq.size() + m_infl) < DEPTH) &&
                 ($urandom_range(0, 9) < 6);
            mul_step(iv, 1'($urandom_range(0, 1)), rand_word());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
